// File: rtl/op_cycle_timer_pkg.sv
// rtl/op_cycle_timer_pkg.sv - shared state type, default widths and saturation helper
package op_cycle_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEF_CNT_W  = 32;
    localparam int DEF_RUNS_W = 16;

    // All-ones value of a w-bit counter, clamped to 64 bits.
    function automatic logic [63:0] sat_max(input int w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/op_cycle_timer_if.sv
// rtl/op_cycle_timer_if.sv - start/core handshake and result readout bundle
interface op_cycle_timer_if #(
    parameter int CNT_W  = op_cycle_timer_pkg::DEF_CNT_W,
    parameter int RUNS_W = op_cycle_timer_pkg::DEF_RUNS_W
);
    logic              start_pulse;
    logic              core_ready;
    logic              core_start;
    logic              core_done;
    logic              result_ack;
    logic              busy;
    logic              result_valid;
    logic [CNT_W-1:0]  cycle_count;
    logic              overflow;
    logic              timeout;
    logic [RUNS_W-1:0] run_count;

    modport master (
        output start_pulse, core_ready, core_done, result_ack,
        input  core_start, busy, result_valid, cycle_count, overflow, timeout, run_count
    );

    modport slave (
        input  start_pulse, core_ready, core_done, result_ack,
        output core_start, busy, result_valid, cycle_count, overflow, timeout, run_count
    );
endinterface

// File: rtl/op_cycle_timer_sat_counter.sv
// rtl/op_cycle_timer_sat_counter.sv - clearable saturating up-counter with sticky overflow
module sat_counter
    import op_cycle_timer_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         overflow
);
    localparam logic [W-1:0] MAX_VAL = W'(sat_max(W));

    logic [W-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;

    // Overflow marks a lost increment, so landing exactly on MAX_VAL is not an overflow.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (enable) begin
            if (count_q == MAX_VAL) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/op_cycle_timer.sv
// rtl/op_cycle_timer.sv - launches one core operation and measures cycles to core_done
module op_cycle_timer
    import op_cycle_timer_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int RUNS_W  = DEF_RUNS_W,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst,
    op_cycle_timer_if.slave bus
);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic              core_start_q, core_start_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;
    logic [RUNS_W-1:0] run_count_q, run_count_d;

    logic [CNT_W-1:0]  cnt;
    logic              cnt_ovf;
    logic              cnt_clear;
    logic              cnt_en;

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .count    (cnt),
        .overflow (cnt_ovf)
    );

    // Counter is cleared on the launch edge so it reads 0 in the core_start cycle.
    always_comb begin
        state_d       = state_q;
        core_start_d  = 1'b0;
        cycle_count_d = cycle_count_q;
        overflow_d    = overflow_q;
        timeout_d     = timeout_q;
        run_count_d   = run_count_q;
        cnt_clear     = 1'b0;
        cnt_en        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_pulse) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (bus.core_ready) begin
                    state_d      = ST_RUN;
                    core_start_d = 1'b1;
                    cnt_clear    = 1'b1;
                end
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (bus.core_done) begin
                    cycle_count_d = cnt;
                    overflow_d    = cnt_ovf;
                    timeout_d     = 1'b0;
                    run_count_d   = run_count_q + RUNS_W'(1);
                    state_d       = ST_DONE;
                end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
                    cycle_count_d = TO_VAL;
                    overflow_d    = cnt_ovf;
                    timeout_d     = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.result_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            core_start_q  <= 1'b0;
            cycle_count_q <= '0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
            run_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            core_start_q  <= core_start_d;
            cycle_count_q <= cycle_count_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
            run_count_q   <= run_count_d;
        end
    end

    assign bus.core_start   = core_start_q;
    assign bus.busy         = (state_q == ST_LAUNCH) || (state_q == ST_RUN);
    assign bus.result_valid = (state_q == ST_DONE);
    assign bus.cycle_count  = cycle_count_q;
    assign bus.overflow     = overflow_q;
    assign bus.timeout      = timeout_q;
    assign bus.run_count    = run_count_q;

endmodule

// File: tb/tb_op_cycle_timer.sv
// tb/tb_op_cycle_timer.sv - drives a TIMEOUT=20 timer and a 4-bit saturating timer in lockstep
module tb_op_cycle_timer;

    typedef struct {
        int stall;
        int n;
        bit extra;
        bit ack_start;
        int a_cnt;
        bit a_to;
        int a_runs;
        int b_cnt;
        bit b_ov;
        int b_runs;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_pulse, core_ready, core_done, result_ack;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    op_cycle_timer_if #(.CNT_W(32), .RUNS_W(16)) ifa ();
    op_cycle_timer_if #(.CNT_W(4),  .RUNS_W(16)) ifb ();

    assign ifa.start_pulse = start_pulse;
    assign ifa.core_ready  = core_ready;
    assign ifa.core_done   = core_done;
    assign ifa.result_ack  = result_ack;
    assign ifb.start_pulse = start_pulse;
    assign ifb.core_ready  = core_ready;
    assign ifb.core_done   = core_done;
    assign ifb.result_ack  = result_ack;

    op_cycle_timer #(.CNT_W(32), .RUNS_W(16), .TIMEOUT(20)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    op_cycle_timer #(.CNT_W(4), .RUNS_W(16), .TIMEOUT(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    int cs_a = 0;
    int cs_b = 0;
    always @(negedge clk) begin
        if (ifa.core_start === 1'b1) cs_a++;
        if (ifb.core_start === 1'b1) cs_b++;
    end

    int   total = 0;
    int   bad   = 0;
    vec_t sb[$];
    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_a_start"}, 64'(ifa.core_start), 64'd0);
        chk({name, "_a_busy"},  64'(ifa.busy), 64'd0);
        chk({name, "_a_valid"}, 64'(ifa.result_valid), 64'd0);
        chk({name, "_a_cnt"},   64'(ifa.cycle_count), 64'd0);
        chk({name, "_a_ovf"},   64'(ifa.overflow), 64'd0);
        chk({name, "_a_to"},    64'(ifa.timeout), 64'd0);
        chk({name, "_a_runs"},  64'(ifa.run_count), 64'd0);
        chk({name, "_b_start"}, 64'(ifb.core_start), 64'd0);
        chk({name, "_b_busy"},  64'(ifb.busy), 64'd0);
        chk({name, "_b_valid"}, 64'(ifb.result_valid), 64'd0);
        chk({name, "_b_cnt"},   64'(ifb.cycle_count), 64'd0);
        chk({name, "_b_runs"},  64'(ifb.run_count), 64'd0);
    endtask

    task automatic do_run(input vec_t v);
        int   t, c, csa0, csb0;
        bit   seen;
        vec_t ev;
        csa0 = cs_a;
        csb0 = cs_b;
        t = cyc;
        start_pulse = 1'b1;
        core_ready  = (v.stall == 0);
        sb.push_back(v);
        @(negedge clk);
        start_pulse = v.extra;
        chk("launch_busy", 64'(ifa.busy), 64'd1);
        for (int i = 0; i < v.stall; i++) begin
            chk("stall_busy", 64'(ifb.busy), 64'd1);
            chk("stall_nostart", 64'(ifb.core_start), 64'd0);
            @(negedge clk);
            start_pulse = 1'b0;
        end
        core_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (ifa.core_start === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                start_pulse = 1'b0;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL core_start_wait: got none expected pulse within 40 cycles");
            void'(sb.pop_front());
            start_pulse = 1'b0;
            return;
        end
        c = cyc;
        chk("start_latency", 64'(c - t), 64'(2 + v.stall));
        for (int j = 0; j <= v.n; j++) begin
            core_done   = (j == v.n);
            start_pulse = v.extra && (j == 1) && (v.n >= 2);
            if (j == v.n) begin
                chk("run_busy", 64'(ifb.busy), 64'd1);
                chk("run_novalid", 64'(ifb.result_valid), 64'd0);
            end
            @(negedge clk);
        end
        core_done   = 1'b0;
        start_pulse = v.extra;
        chk("a_valid", 64'(ifa.result_valid), 64'd1);
        chk("b_valid", 64'(ifb.result_valid), 64'd1);
        chk("a_notbusy", 64'(ifa.busy), 64'd0);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_pop: got empty queue expected entry");
            return;
        end
        ev = sb.pop_front();
        chk("a_cnt",  64'(ifa.cycle_count), 64'(ev.a_cnt));
        chk("a_to",   64'(ifa.timeout), 64'(ev.a_to));
        chk("a_ovf",  64'(ifa.overflow), 64'd0);
        chk("a_runs", 64'(ifa.run_count), 64'(ev.a_runs));
        chk("b_cnt",  64'(ifb.cycle_count), 64'(ev.b_cnt));
        chk("b_ovf",  64'(ifb.overflow), 64'(ev.b_ov));
        chk("b_to",   64'(ifb.timeout), 64'd0);
        chk("b_runs", 64'(ifb.run_count), 64'(ev.b_runs));
        @(negedge clk);
        result_ack  = 1'b1;
        start_pulse = v.ack_start;
        chk("done_hold_valid", 64'(ifb.result_valid), 64'd1);
        chk("done_hold_cnt", 64'(ifb.cycle_count), 64'(ev.b_cnt));
        @(negedge clk);
        result_ack  = 1'b0;
        start_pulse = 1'b0;
        chk("idle_a_busy", 64'(ifa.busy), 64'd0);
        chk("idle_b_busy", 64'(ifb.busy), 64'd0);
        chk("idle_a_valid", 64'(ifa.result_valid), 64'd0);
        chk("idle_b_valid", 64'(ifb.result_valid), 64'd0);
        chk("idle_a_cnt", 64'(ifa.cycle_count), 64'(ev.a_cnt));
        chk("a_start_count", 64'(cs_a - csa0), 64'd1);
        chk("b_start_count", 64'(cs_b - csb0), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int csa0;
        vec_t fresh;
        //          stall n   ex ack a_cnt to a_runs b_cnt ov b_runs
        tbl[0]  = '{0,    10, 0, 0,  10,   0, 1,     10,   0, 1};
        tbl[1]  = '{6,    4,  0, 0,  4,    0, 2,     4,    0, 2};
        tbl[2]  = '{0,    5,  1, 1,  5,    0, 3,     5,    0, 3};
        tbl[3]  = '{0,    0,  0, 0,  0,    0, 4,     0,    0, 4};
        tbl[4]  = '{0,    25, 1, 0,  20,   1, 4,     15,   1, 5};
        tbl[5]  = '{0,    3,  0, 0,  3,    0, 5,     3,    0, 6};
        tbl[6]  = '{2,    19, 0, 0,  19,   0, 6,     15,   1, 7};
        tbl[7]  = '{0,    15, 0, 0,  15,   0, 7,     15,   0, 8};
        tbl[8]  = '{0,    16, 0, 0,  16,   0, 8,     15,   1, 9};
        tbl[9]  = '{0,    20, 0, 0,  20,   1, 8,     15,   1, 10};
        tbl[10] = '{1,    1,  1, 1,  1,    0, 9,     1,    0, 11};

        rst = 1'b1;
        start_pulse = 1'b0;
        core_ready  = 1'b0;
        core_done   = 1'b0;
        result_ack  = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 11; k++) begin
            do_run(tbl[k]);
        end

        // Reset on the launch edge must suppress core_start.
        start_pulse = 1'b1;
        core_ready  = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        rst = 1'b1;
        csa0 = cs_a;
        @(negedge clk);
        chk_zero("rst_launch");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("after_rst_launch");
        chk("rst_launch_nostart", 64'(cs_a - csa0), 64'd0);

        // Reset in the middle of a run.
        start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrun_busy", 64'(ifa.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_run");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("after_rst_run");

        fresh = '{0, 7, 0, 0, 7, 0, 1, 7, 0, 1};
        do_run(fresh);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000");
        $fatal(1);
    end

endmodule
